// File: rtl/sa_az_sequencer.sv
// Auto-zero acquisition sequencer: alternates the AZ mux between signal and zero,
// settles each phase, then fires one ADC conversion per phase and waits for its result.
module sa_az_sequencer #(
  parameter int CNT_W   = 24,
  parameter int AZMUX_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm_i,
  input  logic [CNT_W-1:0]   p_clk_count_precharge,
  input  logic [AZMUX_W-1:0] p_azmux_hi,
  input  logic [AZMUX_W-1:0] p_azmux_lo,
  input  logic [1:0]         p_pc_sel,
  input  logic               adc_valid_i,
  output logic               adc_trig_o,
  output logic [AZMUX_W-1:0] azmux_o,
  output logic               sig_pc1_sw_o,
  output logic               sig_pc2_sw_o,
  output logic               meas_complete_o,
  output logic [7:0]         pair_count_o,
  output logic [2:0]         status_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE_HI = 3'd1,
    MEAS_HI   = 3'd2,
    SETTLE_LO = 3'd3,
    MEAS_LO   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             adc_done;

  // A valid arriving in the same cycle as our own trigger cannot belong to it.
  assign adc_done = adc_valid_i && !adc_trig_o;
  assign status_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      adc_trig_o      <= 1'b0;
      azmux_o         <= '0;
      sig_pc1_sw_o    <= 1'b0;
      sig_pc2_sw_o    <= 1'b0;
      meas_complete_o <= 1'b0;
      pair_count_o    <= 8'd0;
    end else begin
      adc_trig_o      <= 1'b0;
      meas_complete_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_i) begin
            state        <= SETTLE_HI;
            azmux_o      <= p_azmux_hi;
            sig_pc1_sw_o <= p_pc_sel[0];
            sig_pc2_sw_o <= p_pc_sel[1];
            cnt          <= p_clk_count_precharge;
          end
        end
        SETTLE_HI, SETTLE_LO: begin
          // Terminal count checked before decrementing so a zero reload never wraps.
          if (cnt == '0) begin
            state      <= (state == SETTLE_HI) ? MEAS_HI : MEAS_LO;
            adc_trig_o <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MEAS_HI: begin
          if (adc_done) begin
            state        <= SETTLE_LO;
            azmux_o      <= p_azmux_lo;
            sig_pc1_sw_o <= 1'b0;
            sig_pc2_sw_o <= 1'b0;
            cnt          <= p_clk_count_precharge;
          end
        end
        MEAS_LO: begin
          if (adc_done) begin
            meas_complete_o <= 1'b1;
            pair_count_o    <= pair_count_o + 8'd1;
            if (arm_i) begin
              state        <= SETTLE_HI;
              azmux_o      <= p_azmux_hi;
              sig_pc1_sw_o <= p_pc_sel[0];
              sig_pc2_sw_o <= p_pc_sel[1];
              cnt          <= p_clk_count_precharge;
            end else begin
              state        <= IDLE;
              azmux_o      <= '0;
              sig_pc1_sw_o <= 1'b0;
              sig_pc2_sw_o <= 1'b0;
              cnt          <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
